uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- Front end of the UART receiver. It synchronises RX_IN, runs the oversampling edge and bit counters, and produces a majority-voted sampled bit per UART bit period.
- Feeds the receive FSM and the checkers (start, parity, stop, deserializer) with edge_cnt, bit_cnt, sampled_bit and sample_valid.
- Sits between the pad-side RX_IN and the RX control FSM. It consumes that FSM's enable and dat_samp_en.

Parameters:
- Prescale_width, 6: width of Prescale and edge_cnt.
- n_bits, 4: width of bit_cnt.
- SYNC_STAGES, 2: flop stages in the RX_IN synchroniser; legal values are 2 or 3.

Ports:
- clk  in  1  single receiver clock.
- reset  in  1  synchronous, active-high reset.
- RX_IN  in  1  asynchronous serial line; idles high.
- Prescale  in  Prescale_width  oversampling ratio; legal values 8, 16, 32.
- enable  in  1  from FSM; runs the counters.
- dat_samp_en  in  1  from FSM; arms the majority sampler.
- RX_sync  out  1  synchronised RX_IN, for FSM Idle/Valid start detection.
- edge_cnt  out  Prescale_width  oversample tick within the current bit, 0..Prescale-1.
- bit_cnt  out  n_bits  bit index within the frame; start bit is 0.
- sampled_bit  out  1  majority-voted value of the current bit.
- sample_valid  out  1  one-cycle pulse when sampled_bit has just been updated.

Behaviour:
- Reset (synchronous, active-high, priority over all other logic):
  - Sync flops go to 1; RX_sync = 1.
  - edge_cnt = 0, bit_cnt = 0, sampled_bit = 1, sample_valid = 0, prescale_q = 0.
- Synchroniser:
  - RX_sync = RX_IN delayed by SYNC_STAGES cycles.
  - All sampling uses RX_sync, never RX_IN.
- Prescale capture:
  - prescale_q is loaded from Prescale on the cycle enable rises (enable = 1, enable_d = 0).
  - Changes to Prescale mid-frame are ignored until the next rise of enable.
  - On the first enabled cycle, counting uses the value being captured.
- Counters:
  - enable = 0: edge_cnt and bit_cnt clear to 0 on the next edge.
  - enable = 1 and edge_cnt == prescale_q-1: edge_cnt goes to 0 and bit_cnt increments.
  - Otherwise edge_cnt increments.
  - bit_cnt saturates at 2^n_bits-1; it does not wrap.
  - edge_cnt == prescale_q-1 is held for exactly one cycle per bit, and the FSM samples its transitions there.
- Majority sampler (active only when dat_samp_en = 1 and enable = 1):
  - mid = prescale_q >> 1.
  - Capture RX_sync into s0, s1, s2 at edge_cnt == mid-1, mid and mid+1.
  - In the cycle edge_cnt == mid+1, register sampled_bit = maj(s0, s1, RX_sync) and set sample_valid = 1 for that following cycle only.
  - sampled_bit holds its value between updates.
  - dat_samp_en dropping mid-window discards partial samples: no pulse, sampled_bit held.
- Illegal prescale (prescale_q < 4):
  - Counters still run.
  - Sampler is disabled: sample_valid stays 0 and sampled_bit is held.
  - Non-power-of-two values >= 4 are processed with the same mid rule and are not flagged.
- Timing guarantee: sampled_bit for bit k is stable from edge_cnt == mid+2 through edge_cnt == prescale_q-1 of bit k. The FSM and checkers read it there.
- Enable dropping mid-bit (glitch abort or stop error): counters clear next cycle and no sample_valid is issued for the partial bit.
- Enable re-asserting the cycle after it drops (Valid-to-Start back-to-back frames): counting restarts at edge_cnt = 0, bit_cnt = 0 with a fresh prescale_q capture.
- Reset mid-frame: all state returns to reset values in the same edge; no residual pulse.

Decomposition:
- Shared package uart_rx_pkg holds:
  - Prescale_width and n_bits defaults.
  - MIN_PRESCALE = 4.
  - Frame constants: DATA_BITS = 8, START_IDX = 0, PARITY_IDX = 9.
  - The state encoding constants shared with the FSM.
- One sub-module, rx_in_sync: a parameterised SYNC_STAGES flop chain with reset-to-1.
- Counters, prescale capture and the majority sampler live in uart_rx_sampler.

Test Plan:
- Clean sampling: Prescale = 8, enable high for 10 bits, RX_IN toggling 0,1,0,1 per bit period.
  - Required: edge_cnt cycles 0..7, bit_cnt 0..9.
  - sample_valid pulses at edge_cnt 6 of each bit; sampled_bit matches the driven pattern.
- Majority vote: Prescale = 16, line held 1 with a single-cycle 0 pulse landing on the edge_cnt == 8 sample.
  - Required: sampled_bit = 1.
  - Two-cycle 0 pulse covering edge_cnt 7 and 8: sampled_bit = 0.
- Prescale change mid-frame: Prescale = 8, then switched to 16 at bit 3.
  - Required: edge_cnt continues wrapping at 7 until enable drops.
  - After the next enable rise it wraps at 15.
- Abort: enable dropped at bit 2, edge_cnt = 3 (Prescale = 8).
  - Required: edge_cnt = 0 and bit_cnt = 0 next cycle.
  - No sample_valid for bit 2; sampled_bit unchanged.
- Reset and saturation:
  - Synchronous reset asserted mid-frame: next edge all outputs at reset values, RX_sync = 1.
  - enable held for 20 bit periods: bit_cnt sticks at 15.
- Illegal prescale: Prescale = 2.
  - Required: counters wrap at 1; sample_valid never asserts.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants: counter widths, frame layout and the
// receive-FSM state encoding used by the sampler's consumers.
package uart_rx_pkg;

  localparam int PRESCALE_WIDTH_DEF = 6;
  localparam int N_BITS_DEF         = 4;

  // Below this oversampling ratio the three-tap vote window does not fit in a bit
  localparam int MIN_PRESCALE = 4;

  localparam int DATA_BITS  = 8;
  localparam int START_IDX  = 0;
  localparam int PARITY_IDX = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_VALID  = 3'd5
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_in_sync.sv
// Multi-flop synchroniser for the asynchronous RX line; resets to the idle
// (high) level so a reset never looks like a start bit.
module rx_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronised line, oversampling edge/bit counters
// and a three-tap majority sampler centred on the middle of each bit.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int Prescale_width = PRESCALE_WIDTH_DEF,
  parameter int n_bits         = N_BITS_DEF,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      RX_IN,
  input  logic [Prescale_width-1:0] Prescale,
  input  logic                      enable,
  input  logic                      dat_samp_en,
  output logic                      RX_sync,
  output logic [Prescale_width-1:0] edge_cnt,
  output logic [n_bits-1:0]         bit_cnt,
  output logic                      sampled_bit,
  output logic                      sample_valid
);

  localparam logic [Prescale_width-1:0] P_ONE = Prescale_width'(1);
  localparam logic [Prescale_width-1:0] P_MIN = Prescale_width'(MIN_PRESCALE);
  localparam logic [n_bits-1:0]         B_ONE = n_bits'(1);

  logic                      enable_d;
  logic                      enable_rise;
  logic [Prescale_width-1:0] prescale_q;
  logic [Prescale_width-1:0] prescale_eff;
  logic [Prescale_width-1:0] last_edge;
  logic [Prescale_width-1:0] mid;
  logic                      bit_end;
  logic                      sampler_on;
  logic                      at_s0;
  logic                      at_s1;
  logic                      at_s2;
  logic                      s0;
  logic                      s1;
  logic                      have_s0;
  logic                      have_s1;

  rx_in_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rx_in_sync (
    .clk  (clk),
    .reset(reset),
    .d    (RX_IN),
    .q    (RX_sync)
  );

  // The first enabled cycle already counts against the value being captured
  always_comb begin
    enable_rise  = enable & ~enable_d;
    prescale_eff = enable_rise ? Prescale : prescale_q;
    last_edge    = prescale_eff - P_ONE;
    mid          = prescale_eff >> 1;
    bit_end      = (edge_cnt == last_edge);
    sampler_on   = enable & dat_samp_en & (prescale_eff >= P_MIN);
    at_s0        = (edge_cnt == (mid - P_ONE));
    at_s1        = (edge_cnt == mid);
    at_s2        = (edge_cnt == (mid + P_ONE));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_d   <= 1'b0;
      prescale_q <= '0;
    end else begin
      enable_d <= enable;
      if (enable_rise) begin
        prescale_q <= Prescale;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      if (bit_cnt != '1) begin
        bit_cnt <= bit_cnt + B_ONE;
      end
    end else begin
      edge_cnt <= edge_cnt + P_ONE;
    end
  end

  // have_s0/have_s1 chain the three taps so any gap in dat_samp_en or enable
  // inside the window discards the partial vote instead of using stale taps.
  always_ff @(posedge clk) begin
    if (reset) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      have_s0      <= 1'b0;
      have_s1      <= 1'b0;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!sampler_on) begin
        have_s0 <= 1'b0;
        have_s1 <= 1'b0;
      end else if (at_s0) begin
        s0      <= RX_sync;
        have_s0 <= 1'b1;
        have_s1 <= 1'b0;
      end else if (at_s1) begin
        s1      <= RX_sync;
        have_s1 <= have_s0;
        have_s0 <= 1'b0;
      end else if (at_s2) begin
        if (have_s1) begin
          sampled_bit  <= maj3(s0, s1, RX_sync);
          sample_valid <= 1'b1;
        end
        have_s0 <= 1'b0;
        have_s1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: directed scenarios with literal expectations plus
// randomized frames checked every cycle against a time-arithmetic model.
module tb_uart_rx_sampler;

  localparam int PW   = 6;
  localparam int NB   = 4;
  localparam int S    = 2;
  localparam int MAXC = 100000;

  logic          clk = 1'b0;
  logic          reset;
  logic          RX_IN;
  logic [PW-1:0] Prescale;
  logic          enable;
  logic          dat_samp_en;
  logic          RX_sync;
  logic [PW-1:0] edge_cnt;
  logic [NB-1:0] bit_cnt;
  logic          sampled_bit;
  logic          sample_valid;

  always #5 clk = ~clk;

  uart_rx_sampler #(
    .Prescale_width(PW),
    .n_bits        (NB),
    .SYNC_STAGES   (S)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .enable      (enable),
    .dat_samp_en (dat_samp_en),
    .RX_sync     (RX_sync),
    .edge_cnt    (edge_cnt),
    .bit_cnt     (bit_cnt),
    .sampled_bit (sampled_bit),
    .sample_valid(sample_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: frame position from elapsed cycles since enable rose,
  // line value from an input history, votes from per-cycle history records.
  int k = 0;
  int last_rst = 0;
  bit any_rst = 1'b0;
  bit model_on = 1'b0;
  bit prev_en = 1'b0;
  int t0 = 0;
  int fp = 0;
  int n, mid, ones;
  int exp_ec = 0, exp_bc = 0;
  bit exp_rs = 1'b1, exp_sb = 1'b1, exp_sv = 1'b0;
  bit rx_at   [MAXC];
  bit cyc_act [MAXC];
  bit cyc_rs  [MAXC];
  int cyc_ec  [MAXC];

  always @(posedge clk) begin
    cyc_ec[k]  = exp_ec;
    cyc_rs[k]  = exp_rs;
    cyc_act[k] = !reset && enable && dat_samp_en;
    rx_at[k]   = RX_IN;
    if (reset) begin
      last_rst = k;
      any_rst  = 1'b1;
      model_on = 1'b1;
      prev_en  = 1'b0;
      fp       = 0;
      exp_ec   = 0;
      exp_bc   = 0;
      exp_rs   = 1'b1;
      exp_sb   = 1'b1;
      exp_sv   = 1'b0;
    end else begin
      if (enable && !prev_en) begin
        t0 = k;
        fp = int'(Prescale);
      end
      exp_sv = 1'b0;
      if (enable && fp >= 4 && k >= 2) begin
        mid = fp / 2;
        if (cyc_ec[k] == mid + 1 && cyc_act[k] && cyc_act[k-1] && cyc_act[k-2]) begin
          ones   = int'(cyc_rs[k]) + int'(cyc_rs[k-1]) + int'(cyc_rs[k-2]);
          exp_sb = (ones >= 2);
          exp_sv = 1'b1;
        end
      end
      if (enable) begin
        n      = k - t0 + 1;
        exp_ec = n % fp;
        exp_bc = (n / fp > 15) ? 15 : n / fp;
      end else begin
        exp_ec = 0;
        exp_bc = 0;
      end
      exp_rs  = (any_rst && (k - S + 1 <= last_rst)) ? 1'b1 : rx_at[k-S+1];
      prev_en = enable;
    end
    k++;
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("m_edge_cnt", edge_cnt, exp_ec);
      chk("m_bit_cnt", bit_cnt, exp_bc);
      chk("m_rx_sync", RX_sync, exp_rs);
      chk("m_sampled_bit", sampled_bit, exp_sb);
      chk("m_sample_valid", sample_valid, exp_sv);
    end
  end

  int plist [9] = '{4, 5, 6, 8, 12, 16, 32, 2, 3};
  int pulses;
  int p, nbits, len, gap;
  bit bv;

  initial begin
    reset = 1'b1; RX_IN = 1'b1; enable = 1'b0; dat_samp_en = 1'b0; Prescale = 6'd8;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_edge_cnt", edge_cnt, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_sampled_bit", sampled_bit, 1);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_rx_sync", RX_sync, 1);

    // Clean sampling, Prescale 8, alternating bits starting with 0
    Prescale = 6'd8; enable = 1'b1; dat_samp_en = 1'b1; pulses = 0;
    for (int j = 0; j < 80; j++) begin
      RX_IN = ((j / 8) % 2) != 0;
      chk("clean_edge_cnt", edge_cnt, j % 8);
      chk("clean_bit_cnt", bit_cnt, j / 8);
      if (sample_valid === 1'b1) begin
        pulses++;
        chk("clean_pulse_pos", edge_cnt, 6);
        chk("clean_sampled_bit", sampled_bit, (j / 8) % 2);
      end
      tick();
    end
    chk("clean_pulse_count", pulses, 10);
    enable = 1'b0; RX_IN = 1'b1;
    tick();

    // Majority: two-cycle 0 on taps 7,8 in bit 0; single 0 on tap 8 in bit 1
    Prescale = 6'd16; enable = 1'b1;
    for (int j = 0; j < 32; j++) begin
      RX_IN = !(j == 5 || j == 6 || j == 22);
      if (j == 10) begin
        chk("maj_double_valid", sample_valid, 1);
        chk("maj_double_bit", sampled_bit, 0);
      end
      if (j == 26) begin
        chk("maj_single_valid", sample_valid, 1);
        chk("maj_single_bit", sampled_bit, 1);
      end
      tick();
    end
    enable = 1'b0; RX_IN = 1'b1;
    tick();

    // Prescale changed mid-frame is ignored until the next enable rise
    Prescale = 6'd8; enable = 1'b1;
    for (int j = 0; j < 48; j++) begin
      if (j == 24) Prescale = 6'd16;
      if (j == 47) begin
        chk("pchg_wrap7_ec", edge_cnt, 7);
        chk("pchg_wrap7_bc", bit_cnt, 5);
      end
      tick();
    end
    chk("pchg_after_wrap_ec", edge_cnt, 0);
    chk("pchg_after_wrap_bc", bit_cnt, 6);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    for (int j = 0; j < 16; j++) begin
      if (j == 15) chk("pchg_wrap15_ec", edge_cnt, 15);
      tick();
    end
    chk("pchg_new_bit_ec", edge_cnt, 0);
    chk("pchg_new_bit_bc", bit_cnt, 1);
    enable = 1'b0;
    tick();

    // Abort at bit 2, edge 3: bit 1 sampled as 1, bit 2 line is 0 but never voted
    Prescale = 6'd8; enable = 1'b1; dat_samp_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      RX_IN = (j >= 8 && j < 16);
      if (j == 19) enable = 1'b0;
      tick();
    end
    chk("abort_ec", edge_cnt, 0);
    chk("abort_bc", bit_cnt, 0);
    chk("abort_sb", sampled_bit, 1);
    for (int j = 0; j < 10; j++) begin
      chk("abort_no_valid", sample_valid, 0);
      chk("abort_sb_held", sampled_bit, 1);
      tick();
    end

    // Reset mid-frame with the line low
    Prescale = 6'd8; enable = 1'b1; RX_IN = 1'b0;
    for (int j = 0; j < 13; j++) tick();
    chk("pre_rst_sb", sampled_bit, 0);
    reset = 1'b1;
    tick();
    chk("midrst_ec", edge_cnt, 0);
    chk("midrst_bc", bit_cnt, 0);
    chk("midrst_sb", sampled_bit, 1);
    chk("midrst_sv", sample_valid, 0);
    chk("midrst_rs", RX_sync, 1);
    reset = 1'b0; enable = 1'b0; RX_IN = 1'b1;
    tick();

    // Saturation: 20 bit periods at Prescale 4
    Prescale = 6'd4; enable = 1'b1; dat_samp_en = 1'b0;
    for (int j = 0; j < 80; j++) tick();
    chk("sat_bc", bit_cnt, 15);
    chk("sat_ec", edge_cnt, 0);
    enable = 1'b0;
    tick();

    // Illegal prescale 2: counters wrap at 1, no vote ever issued
    Prescale = 6'd2; enable = 1'b1; dat_samp_en = 1'b1;
    for (int j = 0; j < 20; j++) begin
      RX_IN = $urandom_range(0, 1) != 0;
      chk("ill_ec", edge_cnt, j % 2);
      chk("ill_sv", sample_valid, 0);
      tick();
    end
    chk("ill_bc", bit_cnt, 10);
    enable = 1'b0; RX_IN = 1'b1;
    tick();

    // Randomized frames: glitches, sampler gaps, prescale changes, rare resets
    for (int f = 0; f < 120; f++) begin
      p     = plist[$urandom_range(0, 8)];
      nbits = $urandom_range(1, 12);
      len   = nbits * p + $urandom_range(0, p - 1);
      bv    = 1'b1;
      Prescale    = PW'(p);
      enable      = 1'b1;
      dat_samp_en = ($urandom_range(0, 3) != 0);
      for (int j = 0; j < len; j++) begin
        if (j % p == 0) bv = ($urandom_range(0, 1) != 0);
        RX_IN = ($urandom_range(0, 9) == 0) ? ~bv : bv;
        if ($urandom_range(0, 39) == 0) dat_samp_en = ~dat_samp_en;
        if ($urandom_range(0, 29) == 0) Prescale = PW'(plist[$urandom_range(0, 8)]);
        reset = ($urandom_range(0, 499) == 0);
        tick();
      end
      reset  = 1'b0;
      enable = 1'b0;
      gap    = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) tick();
    end

    for (int g = 0; g < 4; g++) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
